// File: rtl/button_scan_scheduler.sv
// rtl/button_scan_scheduler.sv - time-multiplexed debouncer sharing one evaluator across NUM_BTN channels
module button_scan_scheduler #(
    parameter int NUM_BTN      = 4,
    parameter int SAMPLE_DIV   = 1000,
    parameter int STABLE_COUNT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scan_en,
    input  logic [NUM_BTN-1:0]         button_in,
    output logic [NUM_BTN-1:0]         button_level,
    output logic [NUM_BTN-1:0]         button_press,
    output logic [$clog2(NUM_BTN)-1:0] scan_idx
);
    localparam int IDX_W = $clog2(NUM_BTN);
    localparam int PRE_W = $clog2(SAMPLE_DIV);
    localparam int CNT_W = $clog2(STABLE_COUNT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BTN - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_EVAL,
        S_ADVANCE
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = '0;
        sync1_d = button_in;
        sync2_d = sync1_q;

        case (state_q)
            S_WAIT: begin
                if (scan_en) begin
                    if (presc_q == PRE_LAST) begin
                        presc_d = '0;
                        state_d = S_EVAL;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            S_EVAL: begin
                state_d = S_ADVANCE;
                // A single agreeing sample restarts the run of disagreements.
                if (sync2_q[idx_q] == level_q[idx_q]) begin
                    cnt_d[idx_q] = '0;
                end else if (cnt_q[idx_q] == CNT_LAST) begin
                    level_d[idx_q] = ~level_q[idx_q];
                    cnt_d[idx_q]   = '0;
                    press_d[idx_q] = ~level_q[idx_q];
                end else begin
                    cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
                end
            end
            S_ADVANCE: begin
                state_d = S_WAIT;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            presc_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '{default: '0};
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign button_level = level_q;
    assign button_press = press_q;
    assign scan_idx     = idx_q;
endmodule

// File: tb/tb_button_scan_scheduler.sv
// tb/tb_button_scan_scheduler.sv - self-checking bench for button_scan_scheduler
module tb_button_scan_scheduler;
    localparam int NB = 4;
    localparam int SD = 4;
    localparam int SC = 3;

    logic          clk;
    logic          reset;
    logic          scan_en;
    logic [NB-1:0] button_in;
    logic [NB-1:0] button_level;
    logic [NB-1:0] button_press;
    logic [1:0]    scan_idx;

    button_scan_scheduler #(.NUM_BTN(NB), .SAMPLE_DIV(SD), .STABLE_COUNT(SC)) dut (
        .clk(clk),
        .reset(reset),
        .scan_en(scan_en),
        .button_in(button_in),
        .button_level(button_level),
        .button_press(button_press),
        .scan_idx(scan_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int press_cnt [NB];

    // Reference model: position within the current slot plus per-channel run lengths.
    logic [NB-1:0] m_s1, m_s2, m_level, m_press;
    int            m_cnt [NB];
    int            m_pos, m_idx;

    typedef struct {
        logic          rst;
        logic          en;
        logic [NB-1:0] bin;
        int            cycles;
        logic [NB-1:0] exp_level;
        logic [NB-1:0] exp_press;
        logic [1:0]    exp_idx;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [NB-1:0] b);
        int c;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0;
            m_pos = 0; m_idx = 0;
            for (int i = 0; i < NB; i++) m_cnt[i] = 0;
        end else begin
            m_press = '0;
            if (m_pos < SD) begin
                if (e) m_pos++;
            end else if (m_pos == SD) begin
                c = m_idx;
                if (m_s2[c] == m_level[c]) begin
                    m_cnt[c] = 0;
                end else if (m_cnt[c] + 1 == SC) begin
                    m_level[c] = ~m_level[c];
                    m_cnt[c] = 0;
                    if (m_level[c]) m_press[c] = 1'b1;
                end else begin
                    m_cnt[c]++;
                end
                m_pos++;
            end else begin
                m_idx = (m_idx + 1) % NB;
                m_pos = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [NB-1:0] b);
        reset = r; scan_en = e; button_in = b;
        model_step(r, e, b);
        @(posedge clk);
        @(negedge clk);
        check("model_level", int'(button_level), int'(m_level));
        check("model_press", int'(button_press), int'(m_press));
        check("model_idx", int'(scan_idx), m_idx);
        check("press_onehot", int'($countones(button_press) <= 1), 1);
        for (int i = 0; i < NB; i++) if (button_press[i]) press_cnt[i]++;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < NB; i++) press_cnt[i] = 0;
    endtask

    task automatic slot(input logic [NB-1:0] b);
        repeat (SD + 2) cycle(1'b0, 1'b1, b);
    endtask

    task automatic scan(input logic [NB-1:0] b);
        repeat (NB) slot(b);
    endtask

    initial begin
        logic [NB-1:0] rb;
        logic [5:0]    pat;

        vecs[0] = '{1'b1, 1'b0, 4'b0000,  2, 4'b0000, 4'b0000, 2'd0};
        vecs[1] = '{1'b0, 1'b1, 4'b0100,  5, 4'b0000, 4'b0000, 2'd0};
        vecs[2] = '{1'b0, 1'b1, 4'b0100,  1, 4'b0000, 4'b0000, 2'd1};
        vecs[3] = '{1'b0, 1'b1, 4'b0100, 59, 4'b0100, 4'b0100, 2'd2};
        vecs[4] = '{1'b0, 1'b1, 4'b0100,  1, 4'b0100, 4'b0000, 2'd3};
        vecs[5] = '{1'b0, 1'b1, 4'b0100,  6, 4'b0100, 4'b0000, 2'd0};

        for (int v = 0; v < 6; v++) begin
            repeat (vecs[v].cycles) cycle(vecs[v].rst, vecs[v].en, vecs[v].bin);
            check($sformatf("vec%0d_level", v), int'(button_level), int'(vecs[v].exp_level));
            check($sformatf("vec%0d_press", v), int'(button_press), int'(vecs[v].exp_press));
            check($sformatf("vec%0d_idx", v), int'(scan_idx), int'(vecs[v].exp_idx));
        end

        // Channel 1 bounce: visits 1,1,0,1,1,1.
        do_reset();
        pat = 6'b111011;
        for (int v = 0; v < 6; v++) begin
            scan(pat[v] ? 4'b0010 : 4'b0000);
            check($sformatf("bounce_level_v%0d", v), int'(button_level[1]), (v == 5) ? 1 : 0);
        end
        check("bounce_press_cnt1", press_cnt[1], 1);
        check("bounce_press_other", press_cnt[0] + press_cnt[2] + press_cnt[3], 0);

        // Channel 0 rises, then falls without a press pulse.
        do_reset();
        repeat (3) scan(4'b0001);
        check("fall_rise_level", int'(button_level[0]), 1);
        check("fall_rise_press", press_cnt[0], 1);
        press_cnt[0] = 0;
        repeat (2) scan(4'b0000);
        check("fall_hold_level", int'(button_level[0]), 1);
        scan(4'b0000);
        check("fall_level", int'(button_level[0]), 0);
        check("fall_no_press", press_cnt[0], 0);

        // Hold in WAIT with scan_en low.
        do_reset();
        repeat (2) cycle(1'b0, 1'b1, 4'b0000);
        repeat (20) cycle(1'b0, 1'b0, 4'b1111);
        check("hold_idx", int'(scan_idx), 0);
        repeat (3) cycle(1'b0, 1'b1, 4'b1111);
        check("resume_adv_idx", int'(scan_idx), 0);
        cycle(1'b0, 1'b1, 4'b1111);
        check("resume_next_idx", int'(scan_idx), 1);

        // Reset lands on the EVAL that would complete channel 3's flip.
        do_reset();
        repeat (11) slot(4'b1000);
        repeat (SD) cycle(1'b0, 1'b1, 4'b1000);
        check("pre_rst_idx", int'(scan_idx), 3);
        check("pre_rst_level", int'(button_level), 0);
        cycle(1'b1, 1'b1, 4'b1000);
        check("rst_eval_level", int'(button_level), 0);
        check("rst_eval_press", int'(button_press), 0);
        check("rst_eval_idx", int'(scan_idx), 0);
        slot(4'b1000);
        check("restart_idx", int'(scan_idx), 1);
        check("restart_level", int'(button_level), 0);
        check("restart_press3", press_cnt[3], 0);

        // Randomized run against the model.
        do_reset();
        rb = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) rb[$urandom_range(0, NB - 1)] ^= 1'b1;
            cycle($urandom_range(0, 599) == 0, $urandom_range(0, 9) != 0, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
